// File: rtl/qrisc32_lsu.sv
// Qrisc32 load/store stage: one data-bus access per memory op,
// upstream stall while it is outstanding, registered branch redirect.
package risc_pack;
    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  dst_r;
        logic        write_reg;
        logic        read_mem;
        logic        write_mem;
        logic [31:0] val_r1;
        logic [31:0] val_r2;
        logic [31:0] val_dst;
    } pipe_struct;
endpackage

module qrisc32_lsu #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  risc_pack::pipe_struct pipe_mem_in,
    input  logic                  new_address_valid,
    input  logic [31:0]           new_address,
    output risc_pack::pipe_struct pipe_mem_out,
    output logic                  mem_stall,
    output logic                  fetch_redirect_valid,
    output logic [31:0]           fetch_redirect_addr,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic                  dmem_rd,
    output logic                  dmem_wr,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  bus_error,
    output logic                  misalign_error
);

    localparam int CW = $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [31:0]           result, result_n;
    logic [31:0]           addr_n, wdata_n;
    logic                  rd_n, wr_n;
    logic                  berr_n, merr_n;
    risc_pack::pipe_struct out_n;
    logic                  memop;
    logic                  misaligned;

    assign memop      = pipe_mem_in.read_mem | pipe_mem_in.write_mem;
    assign misaligned = |pipe_mem_in.val_r1[1:0];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        result_n  = result;
        addr_n    = dmem_addr;
        wdata_n   = dmem_wdata;
        rd_n      = dmem_rd;
        wr_n      = dmem_wr;
        berr_n    = bus_error;
        merr_n    = misalign_error;
        out_n     = pipe_mem_out;
        mem_stall = 1'b0;
        unique case (state)
            IDLE: begin
                if (memop) begin
                    mem_stall = 1'b1;
                    result_n  = '0;
                    if (misaligned) begin
                        merr_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        addr_n  = pipe_mem_in.val_r1;
                        wdata_n = pipe_mem_in.val_dst;
                        // read wins when both strobes are requested
                        rd_n    = pipe_mem_in.read_mem;
                        wr_n    = ~pipe_mem_in.read_mem & pipe_mem_in.write_mem;
                        cnt_n   = '0;
                        state_n = ACCESS;
                    end
                end else begin
                    out_n = pipe_mem_in;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (dmem_ready) begin
                    if (dmem_rd) result_n = dmem_rdata;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = DONE;
                end else if (cnt == CW'(BUS_TIMEOUT - 1)) begin
                    rd_n     = 1'b0;
                    wr_n     = 1'b0;
                    berr_n   = 1'b1;
                    result_n = '0;
                    state_n  = DONE;
                end else if (cnt != CW'(BUS_TIMEOUT)) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                out_n = pipe_mem_in;
                if (pipe_mem_in.read_mem) out_n.val_dst = result;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            result         <= '0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_rd        <= 1'b0;
            dmem_wr        <= 1'b0;
            bus_error      <= 1'b0;
            misalign_error <= 1'b0;
            pipe_mem_out   <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            result         <= result_n;
            dmem_addr      <= addr_n;
            dmem_wdata     <= wdata_n;
            dmem_rd        <= rd_n;
            dmem_wr        <= wr_n;
            bus_error      <= berr_n;
            misalign_error <= merr_n;
            pipe_mem_out   <= out_n;
        end
    end

    // The redirect is never squashed: any outstanding access is older.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_redirect_valid <= 1'b0;
            fetch_redirect_addr  <= '0;
        end else begin
            fetch_redirect_valid <= new_address_valid;
            fetch_redirect_addr  <= new_address;
        end
    end

endmodule

// File: tb/tb_qrisc32_lsu.sv
// Scoreboard bench for qrisc32_lsu: randomized op stream against a
// word-addressed memory model and a bus slave with random wait states.
module tb_qrisc32_lsu;
    import risc_pack::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    pipe_struct  pin, pout;
    logic        nav;
    logic [31:0] na;
    logic        mem_stall, frv;
    logic [31:0] fra;
    logic [31:0] daddr, dwdata, drdata;
    logic        drd, dwr, dready, berr, merr;

    qrisc32_lsu #(.BUS_TIMEOUT(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .pipe_mem_in          (pin),
        .new_address_valid    (nav),
        .new_address          (na),
        .pipe_mem_out         (pout),
        .mem_stall            (mem_stall),
        .fetch_redirect_valid (frv),
        .fetch_redirect_addr  (fra),
        .dmem_addr            (daddr),
        .dmem_wdata           (dwdata),
        .dmem_rd              (drd),
        .dmem_wr              (dwr),
        .dmem_rdata           (drdata),
        .dmem_ready           (dready),
        .bus_error            (berr),
        .misalign_error       (merr)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    pipe_struct  exp_q[$];
    int          len_q[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bus_mem [logic [29:0]];
    int          plan_wait = 0;
    bit          mon_en = 1'b0;
    bit          exp_berr = 1'b0;
    bit          exp_mis = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rd_bus(input logic [29:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    // Present one op, predict its write-back bundle, wait for acceptance.
    task automatic issue(input pipe_struct p, input int w, input bit nv,
                         input logic [31:0] nadr);
        pipe_struct e;
        bit         mop, mis;
        int         n, exp_stall;
        @(posedge clk);
        #1;
        pin       = p;
        nav       = nv;
        na        = nadr;
        plan_wait = w;
        mon_en    = 1'b1;
        mop       = p.read_mem | p.write_mem;
        mis       = p.val_r1[1:0] != 2'b00;
        e         = p;
        exp_stall = 0;
        if (mop && mis) begin
            exp_mis   = 1'b1;
            exp_stall = 1;
            if (p.read_mem) e.val_dst = '0;
        end else if (mop) begin
            len_q.push_back(w < TO ? w + 1 : TO);
            exp_stall = (w < TO) ? w + 2 : TO + 1;
            if (w >= TO) begin
                exp_berr = 1'b1;
                if (p.read_mem) e.val_dst = '0;
            end else if (p.read_mem) begin
                e.val_dst = rd_ref(p.val_r1[31:2]);
            end else begin
                ref_mem[p.val_r1[31:2]] = p.val_dst;
            end
        end
        exp_q.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            if (n > 60) begin
                errors++;
                checks++;
                $display("FAIL stall_bound: stall still high after %0d cycles", n);
                break;
            end
            @(posedge clk);
            #1 nav = 1'b0;
        end
        chk("stall_cycles", 128'(n), 128'(exp_stall));
    endtask

    task automatic rand_op(output pipe_struct p, output int w);
        int k, r;
        p           = '0;
        p.op        = 4'($urandom);
        p.dst_r     = 5'($urandom);
        p.write_reg = 1'($urandom);
        p.val_r2    = $urandom;
        p.val_dst   = $urandom;
        k           = $urandom_range(0, 9);
        if (k < 4) begin
            p.val_r1 = $urandom;
        end else begin
            p.val_r1    = {24'h0, 6'($urandom), 2'b00};
            p.read_mem  = (k < 7) || (k == 9);
            p.write_mem = (k >= 7);
            if ($urandom_range(0, 15) == 0)
                p.val_r1[1:0] = 2'($urandom_range(1, 3));
        end
        r = $urandom_range(0, 19);
        if (r < 14)      w = $urandom_range(0, 3);
        else if (r < 17) w = $urandom_range(4, 8);
        else if (r == 17) w = TO - 1;
        else             w = $urandom_range(TO, TO + 3);
    endtask

    // Bus slave: answers after plan_wait cycles, checks strobe stability and length.
    initial begin
        int          wc;
        logic [31:0] a0, w0;
        logic        r0, x0;
        dready = 1'b0;
        drdata = '0;
        wc     = 0;
        forever begin
            @(negedge clk);
            dready = 1'b0;
            if (!reset) begin
                wc = 0;
                continue;
            end
            if (drd || dwr) begin
                if (wc == 0) begin
                    a0 = daddr; w0 = dwdata; r0 = drd; x0 = dwr;
                end else begin
                    chk("bus_stable", {daddr, dwdata, drd, dwr}, {a0, w0, r0, x0});
                end
                if (wc == plan_wait) begin
                    dready = 1'b1;
                    if (drd) drdata = rd_bus(daddr[31:2]);
                    else bus_mem[daddr[31:2]] = dwdata;
                end else begin
                    drdata = $urandom;
                end
                wc++;
            end else begin
                if (wc > 0) begin
                    if (len_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL strobe_len: unexpected access of %0d cycles", wc);
                    end else begin
                        chk("strobe_len", 128'(wc), 128'(len_q.pop_front()));
                    end
                    wc = 0;
                end
                dready = ($urandom_range(0, 3) == 0);
                drdata = $urandom;
            end
        end
    end

    // Monitor: an op accepted at an edge shows on pipe_mem_out after it.
    initial begin
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL pipe_out: output %0h with no expected entry", pout);
                end else begin
                    chk("pipe_out", 128'(pout), 128'(exp_q.pop_front()));
                end
            end
            pend = !mem_stall;
        end
    end

    // Redirect: outputs equal the inputs seen one edge earlier.
    initial begin
        logic        pv;
        logic [31:0] pa;
        bit          have;
        have = 1'b0;
        pv   = 1'b0;
        pa   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                have = 1'b0;
                continue;
            end
            if (have && mon_en) begin
                chk("redir_valid", 128'(frv), 128'(pv));
                chk("redir_addr", 128'(fra), 128'(pa));
            end
            pv   = nav;
            pa   = na;
            have = 1'b1;
        end
    end

    initial begin
        pipe_struct p;
        int         w;
        reset = 1'b0;
        pin   = '1;
        nav   = 1'b1;
        na    = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pipe_out", 128'(pout), 128'(0));
        chk("rst_strobes", 128'({drd, dwr}), 128'(0));
        chk("rst_flags", 128'({berr, merr}), 128'(0));
        chk("rst_redirect", 128'({frv, fra}), 128'(0));
        chk("rst_bus", 128'({daddr, dwdata}), 128'(0));
        @(negedge clk);
        #2;
        reset = 1'b1;
        pin   = '0;
        nav   = 1'b0;

        p = '0; p.op = 4'd1; p.val_dst = 32'd5;
        issue(p, 0, 1'b0, 32'h0);
        ref_mem[30'h40] = 32'hCAFE_F00D;
        bus_mem[30'h40] = 32'hCAFE_F00D;
        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h100; p.val_dst = 32'h1;
        issue(p, 0, 1'b0, 32'h0);
        p = '0; p.write_mem = 1'b1; p.val_r1 = 32'h204; p.val_dst = 32'h1234_5678;
        issue(p, 3, 1'b1, 32'h40);
        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h208; p.val_dst = 32'hFFFF;
        issue(p, TO + 4, 1'b0, 32'h0);
        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h204;
        issue(p, 1, 1'b0, 32'h0);
        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h102; p.val_dst = 32'h77;
        issue(p, 0, 1'b0, 32'h0);
        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h100;
        issue(p, TO - 1, 1'b0, 32'h0);

        repeat (150) begin
            rand_op(p, w);
            issue(p, w, ($urandom_range(0, 3) == 0), $urandom);
        end
        p = '0;
        issue(p, 0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("bus_error_sticky", 128'(berr), 128'(exp_berr));
        chk("misalign_sticky", 128'(merr), 128'(exp_mis));
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset in the middle of an access.
        @(posedge clk);
        #1;
        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h10;
        plan_wait = 1000;
        pin = p;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_rd", 128'(drd), 128'(1));
        #1 reset = 1'b0;
        #1;
        chk("arst_strobes", 128'({drd, dwr}), 128'(0));
        chk("arst_pipe_out", 128'(pout), 128'(0));
        chk("arst_flags", 128'({berr, merr}), 128'(0));
        chk("arst_bus", 128'({daddr, frv}), 128'(0));
        pin      = '0;
        exp_berr = 1'b0;
        exp_mis  = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;

        p = '0; p.read_mem = 1'b1; p.val_r1 = 32'h100;
        issue(p, 2, 1'b0, 32'h0);
        p = '0; p.val_dst = 32'd9;
        issue(p, 0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("post_rst_flags", 128'({berr, merr}), 128'({exp_berr, exp_mis}));
        chk("final_q_drained", 128'(exp_q.size() + len_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
